// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared defaults, field offsets and decoded-instruction type for the decode stage
package decode_pkg;

  localparam int DEF_INSTR_W   = 16;
  localparam int DEF_OPC_W     = 4;
  localparam int DEF_REG_IDX_W = 5;

  localparam logic [DEF_OPC_W-1:0] NOP_OPC_DEF  = 4'd0;
  localparam logic [DEF_OPC_W-1:0] LOAD_OPC_DEF = 4'b1000;

  // Field offsets, derived from the widths so non-default builds stay consistent
  function automatic int opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int tgt_w(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int imm_w(input int instr_w, input int opc_w, input int reg_idx_w);
    return instr_w - opc_w - reg_idx_w;
  endfunction

  function automatic int rs1_lsb(input int reg_idx_w);
    return reg_idx_w;
  endfunction

  // Decoded view of a default-width instruction
  typedef struct packed {
    logic [DEF_OPC_W-1:0]                           opcode;
    logic [DEF_REG_IDX_W-1:0]                       rs1;
    logic [DEF_REG_IDX_W-1:0]                       rs2;
    logic [DEF_INSTR_W-DEF_OPC_W-DEF_REG_IDX_W-1:0] imm;
    logic [DEF_REG_IDX_W-1:0]                       dest;
    logic [DEF_INSTR_W-DEF_OPC_W-1:0]               target;
  } decoded_t;

endpackage

// File: rtl/decode_hazard_unit.sv
// rtl/decode_hazard_unit.sv - combinational load-use hazard compare against the execute stage
module decode_hazard_unit
  import decode_pkg::*;
#(
  parameter int                 OPC_W     = DEF_OPC_W,
  parameter int                 REG_IDX_W = DEF_REG_IDX_W,
  parameter logic [OPC_W-1:0]   LOAD_OPC  = LOAD_OPC_DEF
) (
  input  logic                 in_valid,
  input  logic                 ex_valid,
  input  logic [OPC_W-1:0]     ex_opcode,
  input  logic [REG_IDX_W-1:0] ex_dest_idx,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic                 hazard
);

  // A load in execute whose destination feeds either source must stall decode
  always_comb begin
    hazard = in_valid && ex_valid && (ex_opcode == LOAD_OPC) &&
             ((ex_dest_idx == rd1_idx) || (ex_dest_idx == rd2_idx));
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode pipeline stage with handshake, flush, load-use stall; optional DECODE_WB_BYPASS_EN
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int               INSTR_W   = DEF_INSTR_W,
  parameter int               DATA_W    = 16,
  parameter int               OPC_W     = DEF_OPC_W,
  parameter int               REG_IDX_W = DEF_REG_IDX_W,
  parameter logic [OPC_W-1:0] NOP_OPC   = NOP_OPC_DEF,
  parameter logic [OPC_W-1:0] LOAD_OPC  = LOAD_OPC_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_pc_next,
  input  logic [INSTR_W-1:0]                  in_instr,
  input  logic                                in_squash,
  input  logic                                flush,
  output logic [REG_IDX_W-1:0]                rf_rd1_idx,
  output logic [REG_IDX_W-1:0]                rf_rd2_idx,
  input  logic [DATA_W-1:0]                   rf_rd1_data,
  input  logic [DATA_W-1:0]                   rf_rd2_data,
`ifdef DECODE_WB_BYPASS_EN
  input  logic                                wb_valid,
  input  logic [REG_IDX_W-1:0]                wb_idx,
  input  logic [DATA_W-1:0]                   wb_data,
`endif
  input  logic                                ex_valid,
  input  logic [OPC_W-1:0]                    ex_opcode,
  input  logic [REG_IDX_W-1:0]                ex_dest_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OPC_W-1:0]                    out_opcode,
  output logic [DATA_W-1:0]                   out_pc_next,
  output logic [DATA_W-1:0]                   out_rs1_data,
  output logic [DATA_W-1:0]                   out_rs2_data,
  output logic [INSTR_W-OPC_W-REG_IDX_W-1:0]  out_imm,
  output logic [REG_IDX_W-1:0]                out_dest_idx,
  output logic [DATA_W-1:0]                   out_target
);

  localparam int OPC_LSB = opc_lsb(INSTR_W, OPC_W);
  localparam int TGT_W   = tgt_w(INSTR_W, OPC_W);
  localparam int IMM_W   = imm_w(INSTR_W, OPC_W, REG_IDX_W);
  localparam int RS1_LSB = rs1_lsb(REG_IDX_W);

  if (INSTR_W - OPC_W < 2 * REG_IDX_W) begin : g_bad_widths
    $error("decode_stage_pipe: INSTR_W-OPC_W must be >= 2*REG_IDX_W");
  end

  logic [OPC_W-1:0]  dec_opcode;
  logic [IMM_W-1:0]  dec_imm;
  logic [DATA_W-1:0] rs1_sel;
  logic [DATA_W-1:0] rs2_sel;
  logic              hazard;
  logic              advance;

  // Field slicing straight off the fetched instruction
  always_comb begin
    dec_opcode = in_instr[OPC_LSB +: OPC_W];
    dec_imm    = in_instr[RS1_LSB +: IMM_W];
    rf_rd1_idx = in_instr[RS1_LSB +: REG_IDX_W];
    rf_rd2_idx = in_instr[REG_IDX_W-1:0];
    out_target = DATA_W'(in_instr[TGT_W-1:0]);
  end

  // Operand select: register-file data, or the write-back value when it targets a nonzero source
  always_comb begin
`ifdef DECODE_WB_BYPASS_EN
    rs1_sel = (wb_valid && (wb_idx == rf_rd1_idx) && (rf_rd1_idx != '0)) ? wb_data : rf_rd1_data;
    rs2_sel = (wb_valid && (wb_idx == rf_rd2_idx) && (rf_rd2_idx != '0)) ? wb_data : rf_rd2_data;
`else
    rs1_sel = rf_rd1_data;
    rs2_sel = rf_rd2_data;
`endif
  end

  decode_hazard_unit #(
    .OPC_W     (OPC_W),
    .REG_IDX_W (REG_IDX_W),
    .LOAD_OPC  (LOAD_OPC)
  ) u_hazard (
    .in_valid    (in_valid),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_dest_idx (ex_dest_idx),
    .rd1_idx     (rf_rd1_idx),
    .rd2_idx     (rf_rd2_idx),
    .hazard      (hazard)
  );

  // Handshake: the output slot frees when empty or drained; flush overrides the stall
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance && (flush || !hazard);
  end

  // Output register: flush kills, a clean transfer loads, a stall or idle drains, backpressure holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_opcode   <= NOP_OPC;
      out_pc_next  <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_dest_idx <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance && in_valid && !hazard) begin
      out_valid    <= 1'b1;
      out_opcode   <= in_squash ? NOP_OPC : dec_opcode;
      out_pc_next  <= in_pc_next;
      out_rs1_data <= rs1_sel;
      out_rs2_data <= rs2_sel;
      out_imm      <= dec_imm;
      out_dest_idx <= rf_rd2_idx;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed table-driven bench for decode_stage_pipe
module tb_decode_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc_next;
  logic [15:0] in_instr;
  logic        in_squash;
  logic        flush;
  logic [4:0]  rf_rd1_idx;
  logic [4:0]  rf_rd2_idx;
  logic [15:0] rf_rd1_data;
  logic [15:0] rf_rd2_data;
`ifdef DECODE_WB_BYPASS_EN
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [15:0] wb_data;
`endif
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [4:0]  ex_dest_idx;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_pc_next;
  logic [15:0] out_rs1_data;
  logic [15:0] out_rs2_data;
  logic [6:0]  out_imm;
  logic [4:0]  out_dest_idx;
  logic [15:0] out_target;

  int n_checks;
  int n_fails;

  decode_stage_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc_next   (in_pc_next),
    .in_instr     (in_instr),
    .in_squash    (in_squash),
    .flush        (flush),
    .rf_rd1_idx   (rf_rd1_idx),
    .rf_rd2_idx   (rf_rd2_idx),
    .rf_rd1_data  (rf_rd1_data),
    .rf_rd2_data  (rf_rd2_data),
`ifdef DECODE_WB_BYPASS_EN
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
`endif
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_dest_idx  (ex_dest_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_pc_next  (out_pc_next),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_dest_idx (out_dest_idx),
    .out_target   (out_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        squash;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [3:0]  e_opc;
    logic [6:0]  e_imm;
    logic [4:0]  e_dest;
    logic [4:0]  e_rd1;
    logic [4:0]  e_rd2;
    logic [15:0] e_tgt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_pc_next = '0; in_instr = '0; in_squash = 1'b0;
    flush = 1'b0; rf_rd1_data = '0; rf_rd2_data = '0; ex_valid = 1'b0; ex_opcode = '0;
    ex_dest_idx = '0; out_ready = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
`endif

    //                 instr     pc        sq    d1        d2        opc   imm    dest   rd1    rd2    tgt
    vecs[0] = '{16'h30A5, 16'h0002, 1'b0, 16'h1111, 16'h2222, 4'h3, 7'h05, 5'h05, 5'h05, 5'h05, 16'h00A5};
    vecs[1] = '{16'h7123, 16'h0004, 1'b1, 16'h3333, 16'h4444, 4'h0, 7'h09, 5'h03, 5'h09, 5'h03, 16'h0123};
    vecs[2] = '{16'hFFFF, 16'hFFFE, 1'b0, 16'hABCD, 16'h1234, 4'hF, 7'h7F, 5'h1F, 5'h1F, 5'h1F, 16'h0FFF};
    vecs[3] = '{16'h8000, 16'h0010, 1'b0, 16'h5555, 16'hAAAA, 4'h8, 7'h00, 5'h00, 5'h00, 5'h00, 16'h0000};
    vecs[4] = '{16'hC3E0, 16'h0020, 1'b0, 16'h0F0F, 16'hF0F0, 4'hC, 7'h1F, 5'h00, 5'h1F, 5'h00, 16'h03E0};

    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_opcode", out_opcode, 0);
    check("reset out_pc_next", out_pc_next, 0);
    check("reset out_rs1_data", out_rs1_data, 0);
    check("reset out_rs2_data", out_rs2_data, 0);
    check("reset out_imm", out_imm, 0);
    check("reset out_dest_idx", out_dest_idx, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      in_valid    = 1'b1;
      in_instr    = vecs[i].instr;
      in_pc_next  = vecs[i].pc;
      in_squash   = vecs[i].squash;
      rf_rd1_data = vecs[i].d1;
      rf_rd2_data = vecs[i].d2;
      #1;
      check($sformatf("v%0d rf_rd1_idx", i), rf_rd1_idx, vecs[i].e_rd1);
      check($sformatf("v%0d rf_rd2_idx", i), rf_rd2_idx, vecs[i].e_rd2);
      check($sformatf("v%0d out_target", i), out_target, vecs[i].e_tgt);
      check($sformatf("v%0d in_ready", i), in_ready, 1);
      tick();
      check($sformatf("v%0d out_valid", i), out_valid, 1);
      check($sformatf("v%0d out_opcode", i), out_opcode, vecs[i].e_opc);
      check($sformatf("v%0d out_pc_next", i), out_pc_next, vecs[i].pc);
      check($sformatf("v%0d out_imm", i), out_imm, vecs[i].e_imm);
      check($sformatf("v%0d out_dest_idx", i), out_dest_idx, vecs[i].e_dest);
      check($sformatf("v%0d out_rs1_data", i), out_rs1_data, vecs[i].d1);
      check($sformatf("v%0d out_rs2_data", i), out_rs2_data, vecs[i].d2);
    end
    in_valid  = 1'b0;
    in_squash = 1'b0;
    tick();
    check("idle out_valid", out_valid, 0);

    // Load-use stall: rd1 matches the load destination
    in_valid = 1'b1; in_instr = 16'h30A5; in_pc_next = 16'h0100;
    ex_valid = 1'b1; ex_opcode = 4'h8; ex_dest_idx = 5'd5;
    #1;
    check("hazard rd1 in_ready", in_ready, 0);
    tick();
    check("hazard bubble out_valid", out_valid, 0);
    in_instr = 16'h7123; ex_dest_idx = 5'd3;
    #1;
    check("hazard rd2 in_ready", in_ready, 0);
    ex_opcode = 4'h7;
    #1;
    check("non-load in_ready", in_ready, 1);
    ex_opcode = 4'h8; ex_dest_idx = 5'd5; in_instr = 16'h30A5;
    #1;
    check("hazard again in_ready", in_ready, 0);
    ex_valid = 1'b0;
    #1;
    check("hazard cleared in_ready", in_ready, 1);
    tick();
    check("issue after stall out_valid", out_valid, 1);
    check("issue after stall out_opcode", out_opcode, 3);
    check("issue after stall out_pc_next", out_pc_next, 16'h0100);

    // Backpressure with a held entry
    out_ready = 1'b0; in_instr = 16'hFFFF; in_pc_next = 16'h0200;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d in_ready", c), in_ready, 0);
      tick();
      check($sformatf("bp%0d out_valid", c), out_valid, 1);
      check($sformatf("bp%0d out_pc_next", c), out_pc_next, 16'h0100);
      check($sformatf("bp%0d out_opcode", c), out_opcode, 3);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    tick();
    check("bp release out_valid", out_valid, 1);
    check("bp release out_pc_next", out_pc_next, 16'h0200);
    check("bp release out_opcode", out_opcode, 4'hF);

    // Flush while backpressured and hazarded
    out_ready = 1'b0; ex_valid = 1'b1; ex_opcode = 4'h8; ex_dest_idx = 5'd5;
    in_instr = 16'h30A5; in_pc_next = 16'h0300; flush = 1'b1;
    #1;
    check("flush bp in_ready", in_ready, 0);
    tick();
    check("flush out_valid", out_valid, 0);
    check("flush stall in_ready", in_ready, 1);
    check("flush no load out_pc_next", out_pc_next, 16'h0200);
    flush = 1'b0;
    #1;
    check("post flush hazard in_ready", in_ready, 0);
    tick();
    check("post flush bubble out_valid", out_valid, 0);

    // Asynchronous reset drops a loaded entry without a clock edge
    ex_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("pre reset out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_pc_next", out_pc_next, 0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

`ifdef DECODE_WB_BYPASS_EN
    in_valid = 1'b1; in_instr = 16'h30A5; in_pc_next = 16'h0400;
    rf_rd1_data = 16'h0000; rf_rd2_data = 16'h1111;
    wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 16'hBEEF;
    tick();
    check("bypass rs1", out_rs1_data, 16'hBEEF);
    check("bypass rs2", out_rs2_data, 16'hBEEF);
    in_instr = 16'h8000; wb_idx = 5'd0; rf_rd1_data = 16'h0000;
    tick();
    check("bypass idx0 rs1", out_rs1_data, 16'h0000);
    wb_valid = 1'b0;
    in_valid = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised instruction-decode pipeline stage between fetch and execute.
- Splits the fetched instruction into opcode, register indices, immediate, target and destination.
- Drives register-file read indices and registers the operands for the execute stage.
- Adds what the fixed 16-bit stage lacks: valid/ready handshake with backpressure, flush, load-use hazard stall with bubble insertion, and asynchronous reset.

Parameters:
- INSTR_W, 16, instruction width.
- DATA_W, 16, register/PC data width.
- OPC_W, 4, opcode field width (top bits of the instruction).
- REG_IDX_W, 5, register index width. Elaboration error unless INSTR_W-OPC_W >= 2*REG_IDX_W.
- NOP_OPC, 0, opcode emitted for squashed instructions.
- LOAD_OPC, 4'b1000, opcode that marks a load in execute for hazard detection.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc_next  in  DATA_W  next program counter from fetch.
- in_instr  in  INSTR_W  fetched instruction.
- in_squash  in  1  branch predictor: convert the accepted instruction to NOP.
- flush  in  1  kill the output register and discard the incoming instruction.
- rf_rd1_idx  out  REG_IDX_W  register-file read index 1 = instr[2*REG_IDX_W-1:REG_IDX_W].
- rf_rd2_idx  out  REG_IDX_W  register-file read index 2 = instr[REG_IDX_W-1:0].
- rf_rd1_data  in  DATA_W  register-file read data 1.
- rf_rd2_data  in  DATA_W  register-file read data 2.
- ex_valid  in  1  execute holds a valid instruction.
- ex_opcode  in  OPC_W  opcode in execute.
- ex_dest_idx  in  REG_IDX_W  destination register in execute.
- out_valid  out  1  output register holds a valid entry.
- out_ready  in  1  execute consumes the entry.
- out_opcode  out  OPC_W  registered control.
- out_pc_next  out  DATA_W  registered next PC.
- out_rs1_data  out  DATA_W  registered operand 1.
- out_rs2_data  out  DATA_W  registered operand 2.
- out_imm  out  INSTR_W-OPC_W-REG_IDX_W  registered instr[INSTR_W-OPC_W-1:REG_IDX_W].
- out_dest_idx  out  REG_IDX_W  registered instr[REG_IDX_W-1:0].
- out_target  out  DATA_W  combinational instr[INSTR_W-OPC_W-1:0], zero-extended to DATA_W.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_opcode=NOP_OPC, all other registered outputs 0.
- rf_rd*_idx decode combinationally from in_instr at all times.
- Definitions:
  - hazard = in_valid & ex_valid & (ex_opcode==LOAD_OPC) & (ex_dest_idx==rf_rd1_idx | ex_dest_idx==rf_rd2_idx).
  - advance = !out_valid | out_ready.
- in_ready = advance & (flush | !hazard).
- Latency: 1 cycle, in transfer to out_valid.
- Priority at the clock edge:
  - flush: out_valid<=0, input discarded, no stall.
  - else advance & in_valid & !hazard: load all fields, out_valid<=1, out_opcode = in_squash ? NOP_OPC : opcode.
  - else advance & hazard: bubble; out_valid<=0, input held upstream.
  - else advance & !in_valid: out_valid<=0.
  - else (!advance): hold all outputs stable.
- A squashed entry is still valid (NOP travels down the pipe). Operand fields load normally and are don't-care.
- Simultaneous hazard & !advance: hold, in_ready=0. The hazard is re-evaluated each cycle.
- Reset mid-stall: the entry is lost and the upstream is not re-requested.

Optional Feature:
- DECODE_WB_BYPASS_EN.
- When defined, adds inputs wb_valid (1), wb_idx (REG_IDX_W) and wb_data (DATA_W).
  - If wb_valid and wb_idx==rf_rdN_idx and the index is nonzero, the stage latches wb_data instead of rf_rdN_data.
  - Covers same-cycle write/read in the register file.
- When undefined, the ports are absent and the stage latches register-file data unconditionally.

Decomposition:
- Package decode_pkg holds:
  - NOP_OPC and LOAD_OPC defaults.
  - The field-slice offset constants.
  - A decoded-instruction struct typedef (opcode, rs1, rs2, imm, dest, target).
- One sub-module, decode_hazard_unit: purely combinational hazard compare, reusable by later forwarding logic.

Test Plan:
- Reset then idle: instr=16'h3_0A5, in_valid=1, out_ready=1, then in_valid=0.
  - Next edge: out_opcode=3, out_imm=7'h05, out_dest_idx=5, rf_rd1_idx=5, rf_rd2_idx=5.
  - out_valid=1 for exactly 1 cycle.
- Squash: instr=16'h7_123, in_squash=1.
  - out_valid=1, out_opcode=0, out_pc_next passes through.
- Load-use: ex_valid=1, ex_opcode=8, ex_dest_idx=5; in_instr rd1=5.
  - in_ready=0 and one bubble (out_valid=0).
  - Drop ex_valid: the instruction issues next edge.
- Backpressure: out_ready=0 for 3 cycles with an entry held.
  - Outputs stable, in_ready=0.
  - Release: held entry consumed, then the new one loads.
- Flush during stall and backpressure: out_valid=0 next edge, in_ready=1 that cycle.
- DECODE_WB_BYPASS_EN: wb_valid=1, wb_idx=5, wb_data=16'hBEEF while rf_rd1_data=16'h0000.
  - out_rs1_data=16'hBEEF.
  - With wb_idx=0: 16'h0000.
